// File: rtl/pdp1_rim.sv
// pdp1_rim
// Revision constant for the RIM loader; the loader top lives in
// pdp1_rim_loader.sv.
package pdp1_rim_version_pkg;
  localparam int RIM_LOADER_REV = 1;
endpackage

// File: rtl/pdp1_rim_pkg.sv
// pdp1_rim_pkg
// Shared definitions for the PDP-1 RIM (read-in mode) paper-tape loader:
// FSM state encoding, the two RIM opcodes, and the tape line geometry.
// A RIM word is three 6-bit tape lines; its top six bits are the opcode,
// and its low twelve bits are the address field.
package pdp1_rim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } rim_state_t;

  localparam logic [5:0] OPC_DIO = 6'o32;
  localparam logic [5:0] OPC_JMP = 6'o60;

  localparam int RIM_LINES    = 3;
  localparam int LINE_W       = 6;
  localparam int LINE_CNT_W   = 2;
  localparam int ASM_W        = LINE_W * RIM_LINES;
  localparam int ADDR_FIELD_W = 12;

  // Opcode field of an assembled word (top tape line).
  function automatic logic [LINE_W-1:0] rim_opcode(input logic [ASM_W-1:0] word);
    return word[ASM_W-1 -: LINE_W];
  endfunction

  // Address field of an assembled word (low twelve bits).
  function automatic logic [ADDR_FIELD_W-1:0] rim_addr_field(input logic [ASM_W-1:0] word);
    return word[ADDR_FIELD_W-1:0];
  endfunction

endpackage

// File: rtl/pdp1_rim_word_assembler.sv
// pdp1_rim_word_assembler
// Collects hole-8 tape lines into 18-bit words, first line in the MSBs.
// Bytes without the hole-8 flag are ignored and do not advance the count.
// Ports:
//   clock       - clock
//   reset       - synchronous active-high reset
//   clear       - drop any partial word and restart the line count
//   byte_accept - a tape byte is being accepted this cycle
//   byte_data   - the tape byte (bit7 hole-8 flag, bits5:0 data line)
//   word_valid  - one-cycle strobe: this accepted byte completes a word
//   word        - assembled word, valid while word_valid is high
module pdp1_rim_word_assembler
  import pdp1_rim_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             byte_accept,
  input  logic [7:0]       byte_data,
  output logic             word_valid,
  output logic [ASM_W-1:0] word
);

  localparam int SR_W = LINE_W * (RIM_LINES - 1);

  logic [SR_W-1:0]       shift_reg;
  logic [LINE_CNT_W-1:0] count_reg;
  logic                  line_accept;
  logic                  unused_bit6;

  // Bit 6 of the tape byte carries no information in RIM format.
  assign unused_bit6 = byte_data[6];

  assign line_accept = byte_accept && byte_data[7];

  // The word is presented combinationally on the third line so the loader
  // can act on the same clock edge that accepts that line.
  assign word_valid = line_accept && (count_reg == LINE_CNT_W'(RIM_LINES - 1));
  assign word       = {shift_reg, byte_data[LINE_W-1:0]};

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      shift_reg <= '0;
      count_reg <= '0;
    end else if (line_accept) begin
      shift_reg <= {shift_reg[SR_W-LINE_W-1:0], byte_data[LINE_W-1:0]};
      count_reg <= word_valid ? '0 : count_reg + LINE_CNT_W'(1);
    end
  end

endmodule

// File: rtl/pdp1_rim_loader.sv
// pdp1_rim_loader
// Paper-tape RIM loader for a PDP-1 style main memory. After start it reads
// hole-8 lines from the tape byte stream, decodes dio/data word pairs into
// RAM writes on port B, and stops on a jmp word, reporting its target.
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   start                 - one-cycle load request (honoured in IDLE/ERROR)
//   rx_valid/rx_data      - tape byte stream in
//   rx_ready              - byte accepted when rx_valid && rx_ready
//   ram_address/ram_data  - RAM write address/data (held between writes)
//   ram_wren              - one-cycle RAM write enable
//   busy                  - load in progress
//   done                  - one-cycle pulse on reaching the jmp word
//   error                 - unknown command opcode seen; held until start/reset
//   start_address         - jmp target of the last completed load
//   words_loaded          - data words written in this load (saturating)
module pdp1_rim_loader
  import pdp1_rim_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 18
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [WORD_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] start_address,
  output logic [ADDR_W-1:0] words_loaded
);

  rim_state_t        state_reg;
  logic              rx_ready_reg;
  logic [ADDR_W-1:0] ram_address_reg;
  logic [WORD_W-1:0] ram_data_reg;
  logic              ram_wren_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              error_reg;
  logic [ADDR_W-1:0] start_address_reg;
  logic [ADDR_W-1:0] words_loaded_reg;
  logic [ADDR_W-1:0] target_reg;

  logic              byte_accept;
  logic              start_ok;
  logic              word_valid;
  logic [ASM_W-1:0]  asm_word;
  logic [ADDR_W-1:0] asm_addr;

  assign byte_accept = rx_valid && rx_ready_reg;
  assign start_ok    = start && (state_reg == ST_IDLE || state_reg == ST_ERROR);
  assign asm_addr    = ADDR_W'(rim_addr_field(asm_word));

  pdp1_rim_word_assembler u_assembler (
    .clock       (clock),
    .reset       (reset),
    .clear       (start_ok),
    .byte_accept (byte_accept),
    .byte_data   (rx_data),
    .word_valid  (word_valid),
    .word        (asm_word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      rx_ready_reg      <= 1'b0;
      ram_address_reg   <= '0;
      ram_data_reg      <= '0;
      ram_wren_reg      <= 1'b0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      error_reg         <= 1'b0;
      start_address_reg <= '0;
      words_loaded_reg  <= '0;
      target_reg        <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_ERROR: begin
          if (start_ok) begin
            state_reg        <= ST_CMD;
            rx_ready_reg     <= 1'b1;
            busy_reg         <= 1'b1;
            error_reg        <= 1'b0;
            words_loaded_reg <= '0;
          end
        end

        ST_CMD: begin
          if (word_valid) begin
            if (rim_opcode(asm_word) == OPC_DIO) begin
              target_reg <= asm_addr;
              state_reg  <= ST_DATA;
            end else if (rim_opcode(asm_word) == OPC_JMP) begin
              start_address_reg <= asm_addr;
              state_reg         <= ST_DONE;
              rx_ready_reg      <= 1'b0;
              busy_reg          <= 1'b0;
              done_reg          <= 1'b1;
            end else begin
              state_reg    <= ST_ERROR;
              rx_ready_reg <= 1'b0;
              busy_reg     <= 1'b0;
              error_reg    <= 1'b1;
            end
          end
        end

        ST_DATA: begin
          // Stall the tape during the write cycle so nothing is accepted
          // while the word is being committed.
          if (word_valid) begin
            state_reg       <= ST_WRITE;
            rx_ready_reg    <= 1'b0;
            ram_wren_reg    <= 1'b1;
            ram_address_reg <= target_reg;
            ram_data_reg    <= WORD_W'(asm_word);
          end
        end

        ST_WRITE: begin
          state_reg    <= ST_CMD;
          rx_ready_reg <= 1'b1;
          ram_wren_reg <= 1'b0;
          if (words_loaded_reg != '1) begin
            words_loaded_reg <= words_loaded_reg + ADDR_W'(1);
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
        end

        default: begin
          state_reg    <= ST_IDLE;
          rx_ready_reg <= 1'b0;
          ram_wren_reg <= 1'b0;
          busy_reg     <= 1'b0;
          done_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready      = rx_ready_reg;
  assign ram_address   = ram_address_reg;
  assign ram_data      = ram_data_reg;
  assign ram_wren      = ram_wren_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign error         = error_reg;
  assign start_address = start_address_reg;
  assign words_loaded  = words_loaded_reg;

endmodule
